fetch_controller: RTL and testbench

Sequences instruction fetch into the instruction queue. Owns the PC and issues in-order requests to instruction memory. Reserves one queue slot per request using a credit counter, so the queue never overflows. On a redirect (branch flush, jump or prediction), it restarts at the new PC and drops responses that are still in flight from before the redirect. Sits between imem and the instruction queue, ahead of decode.

---
 rtl/fetch_controller_pkg.sv | 13 +
 rtl/fetch_controller_pc_fifo.sv | 41 ++++
 rtl/fetch_controller.sv | 130 +++++++++++++
 tb/tb_fetch_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared fetch-side types and constants for the rv32i core.
// Package rv32i_types: fetch FSM states, reset PC, queue depth.
package rv32i_types;

    localparam int          IQUEUE_DEPTH   = 4;
    localparam logic [31:0] FETCH_RESET_PC = 32'h1eceb000;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_controller_pc_fifo.sv
// In-order FIFO of request PCs, one entry per outstanding imem request.
// Cleared only by rst: dropped responses still pop it.
module fetch_pc_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [31:0] pc_i,
    input  logic        pop_i,
    output logic [31:0] pc_o
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;

    always_comb begin
        wr_d = wr_q + (AW+1)'(push_i);
        rd_d = rd_q + (AW+1)'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= pc_i;
    end

    assign pc_o = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, credit-limits imem requests, drops stale
// responses after a redirect. Optional FETCH_PERF_COUNTERS_EN adds counters.
module fetch_controller
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC        = FETCH_RESET_PC,
    parameter int          QUEUE_DEPTH     = IQUEUE_DEPTH,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        iq_enqueue,
    output logic [31:0] iq_wdata,
    output logic [31:0] iq_pc,
    input  logic        iq_pop,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        busy
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_stall_full,
    output logic [31:0] perf_discarded
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int IW = $clog2(MAX_OUTSTANDING) + 1;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [CW-1:0] credits_q, credits_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic [IW-1:0] discard_q, discard_d;

    logic        accept;
    logic        keep;
    logic [31:0] fifo_pc;

    fetch_pc_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (accept),
        .pc_i   (pc_q),
        .pop_i  (imem_resp),
        .pc_o   (fifo_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            credits_q  <= CW'(QUEUE_DEPTH);
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            credits_q  <= credits_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    // Redirect overrides every other update in the same cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        credits_d  = credits_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            credits_d  = CW'(QUEUE_DEPTH);
            inflight_d = inflight_q - IW'(imem_resp);
            discard_d  = inflight_d;
            state_d    = (discard_d != '0) ? DRAIN : RUN;
        end else begin
            if (accept) pc_d = pc_q + 32'd4;
            credits_d  = credits_q - CW'(accept) + CW'(iq_pop);
            inflight_d = inflight_q + IW'(accept) - IW'(imem_resp);
            if (imem_resp && discard_q != '0) discard_d = discard_q - 1'b1;
            if (state_q == DRAIN && discard_q == '0) state_d = RUN;
        end
    end

    always_comb begin
        imem_req   = !rst && state_q == RUN && credits_q != '0 &&
                     inflight_q < IW'(MAX_OUTSTANDING) && !redirect_valid;
        accept     = imem_req && imem_ready;
        keep       = !rst && imem_resp && discard_q == '0 && !redirect_valid;
        imem_addr  = pc_q;
        iq_enqueue = keep;
        iq_wdata   = keep ? imem_rdata : '0;
        iq_pc      = keep ? fifo_pc : '0;
        busy       = !rst && (inflight_q != '0 || state_q == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid)
            assert (!(iq_pop && credits_q == CW'(QUEUE_DEPTH)));
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] stall_q;
    logic [31:0] disc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            disc_q  <= '0;
        end else begin
            if (state_q == RUN && credits_q == '0 && stall_q != '1)
                stall_q <= stall_q + 32'd1;
            if (imem_resp && !keep && disc_q != '1)
                disc_q <= disc_q + 32'd1;
        end
    end

    assign perf_stall_full = stall_q;
    assign perf_discarded  = disc_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed plus random bench for fetch_controller against an epoch-based
// model of in-flight requests and queue occupancy.
module tb_fetch_controller;
    import rv32i_types::*;

    localparam int          QD  = IQUEUE_DEPTH;
    localparam int          MO  = 4;
    localparam logic [31:0] RPC = 32'h1eceb000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        iq_enqueue;
    logic [31:0] iq_wdata;
    logic [31:0] iq_pc;
    logic        iq_pop;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_stall_full;
    logic [31:0] perf_discarded;
`endif

    fetch_controller #(
        .RESET_PC        (RPC),
        .QUEUE_DEPTH     (QD),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .iq_enqueue     (iq_enqueue),
        .iq_wdata       (iq_wdata),
        .iq_pc          (iq_pc),
        .iq_pop         (iq_pop),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .perf_stall_full (perf_stall_full),
        .perf_discarded  (perf_discarded)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each in-flight request remembers the redirect epoch it was issued in.
    typedef struct {
        logic [31:0] pc;
        int          ep;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] enq_log[$];
    logic [31:0] acc_log[$];
    int          epoch;
    int          occ;
    bit          drain_m;
    logic [31:0] pc_m;
    int          stall_m;
    int          disc_m;
    int          n_vec;
    int          n_err;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a5a0f0f;
    endfunction

    function automatic int live_cnt();
        int c = 0;
        foreach (mq[i]) if (mq[i].ep == epoch) c++;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        enq_log.delete();
        acc_log.delete();
        epoch   = 0;
        occ     = 0;
        drain_m = 1'b0;
        pc_m    = RPC;
        stall_m = 0;
        disc_m  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        imem_ready     = 1'b0;
        imem_resp      = 1'b0;
        imem_rdata     = '0;
        iq_pop         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        @(posedge clk);
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, RPC);
        chk("rst_iq_enqueue", iq_enqueue, 0);
        chk("rst_iq_wdata", iq_wdata, 0);
        chk("rst_iq_pc", iq_pc, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input bit redir, input logic [31:0] rpc,
                        input bit rdy, input bit resp_en, input bit pop_en);
        bit   resp;
        bit   pop;
        bit   exp_req;
        bit   exp_enq;
        int   credits;
        int   stale;
        ent_t h;
        @(negedge clk);
        resp           = resp_en && mq.size() > 0;
        pop            = pop_en && occ > 0;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_ready     = rdy;
        imem_resp      = resp;
        iq_pop         = pop;
        imem_rdata     = resp ? word(mq[0].pc) : $urandom;
        #1;
        credits = QD - occ - live_cnt();
        stale   = mq.size() - live_cnt();
        exp_req = !drain_m && credits > 0 && mq.size() < MO && !redir;
        exp_enq = resp && mq[0].ep == epoch && !redir;
        chk("imem_req", imem_req, exp_req);
        chk("imem_addr", imem_addr, pc_m);
        chk("iq_enqueue", iq_enqueue, exp_enq);
        if (exp_enq) begin
            chk("iq_wdata", iq_wdata, word(mq[0].pc));
            chk("iq_pc", iq_pc, mq[0].pc);
        end
        chk("busy", busy, mq.size() > 0 || drain_m);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("perf_stall_full", perf_stall_full, stall_m);
        chk("perf_discarded", perf_discarded, disc_m);
`endif
        if (iq_enqueue) enq_log.push_back(iq_pc);
        if (imem_req && rdy) acc_log.push_back(imem_addr);
        if (!drain_m && credits == 0) stall_m++;
        if (resp) begin
            h = mq.pop_front();
            if (exp_enq) occ++;
            else disc_m++;
        end
        if (redir) begin
            epoch++;
            pc_m    = rpc;
            occ     = 0;
            drain_m = mq.size() > 0;
        end else begin
            if (pop) occ--;
            if (exp_req && rdy) begin
                h.pc = pc_m;
                h.ep = epoch;
                mq.push_back(h);
                pc_m += 32'd4;
            end
            if (drain_m && stale == 0) drain_m = 1'b0;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();

        // Sequential fetch with one-cycle response latency.
        do_reset();
        repeat (5) step(0, '0, 1, 1, 0);
        chk("seq_count", enq_log.size() >= 3, 1);
        if (enq_log.size() >= 3) begin
            chk("seq_pc0", enq_log[0], 32'h1eceb000);
            chk("seq_pc1", enq_log[1], 32'h1eceb004);
            chk("seq_pc2", enq_log[2], 32'h1eceb008);
        end

        // Credits exhausted with no pops; a single pop frees one request.
        do_reset();
        repeat (10) step(0, '0, 1, 1, 0);
        chk("credit_limit", acc_log.size(), QD);
        acc_log.delete();
        step(0, '0, 0, 0, 1);
        repeat (6) step(0, '0, 1, 1, 0);
        chk("one_more", acc_log.size(), 1);

        // Redirect with three outstanding: stale responses dropped.
        do_reset();
        repeat (3) step(0, '0, 1, 0, 0);
        acc_log.delete();
        step(1, 32'h1eceb100, 1, 0, 0);
        repeat (3) step(0, '0, 1, 1, 0);
        chk("stale_dropped", enq_log.size(), 0);
        repeat (4) step(0, '0, 1, 0, 0);
        chk("redir_issued", acc_log.size() > 0, 1);
        if (acc_log.size() > 0)
            chk("redir_addr", acc_log[0], 32'h1eceb100);

        // Redirect with response and pop, then a second redirect in DRAIN.
        do_reset();
        repeat (2) step(0, '0, 1, 1, 0);
        repeat (2) step(0, '0, 1, 0, 0);
        step(1, 32'h1eceb200, 1, 1, 1);
        chk("drain_busy", busy, 1);
        step(1, 32'h1eceb300, 1, 0, 0);
        enq_log.delete();
        repeat (10) step(0, '0, 1, 1, 0);
        chk("redir2_count", enq_log.size() > 0, 1);
        if (enq_log.size() > 0)
            chk("redir2_pc", enq_log[0], 32'h1eceb300);

        // Queue held full with no pops.
        do_reset();
        repeat (14) step(0, '0, 1, 1, 0);

        // Random traffic with one mid-run reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom % 16 == 0, $urandom & 32'hfffffffc,
                 $urandom % 4 != 0, $urandom % 3 != 0, $urandom % 2 == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
